// File: rtl/wigend_out.sv
// Wiegand-26 transmitter: shifts a host-supplied word out MSB first as low pulses
// on D0/D1, then holds both lines high for a guard gap before reporting done.
module wigend_out #(
  parameter int NBITS      = 26,
  parameter int PULSE_CYC  = 100,
  parameter int PERIOD_CYC = 2000,
  parameter int GAP_CYC    = 6000
) (
  input  logic             wil_clk,
  input  logic             rst,
  input  logic [NBITS-1:0] data,
  input  logic             start,
  output logic [1:0]       wigend,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    SPACE = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam logic [12:0] PULSE_LAST  = 13'(PULSE_CYC - 1);
  localparam logic [12:0] PERIOD_LAST = 13'(PERIOD_CYC - 1);
  localparam logic [12:0] GAP_LAST    = 13'(GAP_CYC - 1);
  localparam logic [4:0]  LAST_BIT    = 5'(NBITS - 1);

  state_t             state_q, state_d;
  logic [NBITS-1:0]   shreg_q, shreg_d;
  logic [4:0]         bitcnt_q, bitcnt_d;
  logic [12:0]        cyc_q, cyc_d;
  logic [1:0]         wigend_q, wigend_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Line pattern for one bit: '1' pulls D1 low, '0' pulls D0 low; never both.
  function automatic logic [1:0] line_low(input logic b);
    return b ? 2'b01 : 2'b10;
  endfunction

  // Next-state and output decode; cyc spans the whole bit period (pulse + space).
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    cyc_d    = cyc_q + 13'd1;
    wigend_d = wigend_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cyc_d = 13'd0;
        if (start) begin
          shreg_d  = data;
          bitcnt_d = 5'd0;
          busy_d   = 1'b1;
          wigend_d = line_low(data[NBITS-1]);
          state_d  = PULSE;
        end else begin
          wigend_d = 2'b11;
          busy_d   = 1'b0;
        end
      end
      PULSE: begin
        if (cyc_q == PULSE_LAST) begin
          wigend_d = 2'b11;
          state_d  = SPACE;
        end else begin
          state_d = PULSE;
        end
      end
      SPACE: begin
        if (cyc_q == PERIOD_LAST) begin
          cyc_d = 13'd0;
          if (bitcnt_q < LAST_BIT) begin
            shreg_d  = shreg_q << 1;
            bitcnt_d = bitcnt_q + 5'd1;
            wigend_d = line_low(shreg_q[NBITS-2]);
            state_d  = PULSE;
          end else begin
            state_d = GAP;
          end
        end else begin
          state_d = SPACE;
        end
      end
      GAP: begin
        if (cyc_q == GAP_LAST) begin
          cyc_d   = 13'd0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = GAP;
        end
      end
      default: begin
        state_d  = IDLE;
        cyc_d    = 13'd0;
        wigend_d = 2'b11;
        busy_d   = 1'b0;
      end
    endcase
  end

  // All state and outputs registered; reset forces the lines high at once.
  always_ff @(posedge wil_clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= 5'd0;
      cyc_q    <= 13'd0;
      wigend_q <= 2'b11;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      cyc_q    <= cyc_d;
      wigend_q <= wigend_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign wigend = wigend_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_wigend_out.sv
// Directed bench for wigend_out: receiver model on a scaled-timing instance plus
// a cycle-exact waveform check on a tiny-timing instance.
module tb_wigend_out;

  localparam int PA = 10, PERA = 40, GA = 120;
  localparam int FRAME_A = 26 * PERA + GA;
  localparam int PB = 2, PERB = 5, GB = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [25:0] data_a = 26'd0, data_b = 26'd0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [1:0]  wig_a, wig_b;
  logic        busy_a, done_a, busy_b, done_b;

  int total = 0, bad = 0;
  int tcyc = 0, t_start = 0, tb_start = 0;

  logic [1:0]  prev_a = 2'b11;
  logic [25:0] rx_word = 26'd0;
  int rx_cnt = 0, d0_cnt = 0, d1_cnt = 0, width_err = 0, period_err = 0;
  int both_low = 0, done_cnt = 0, fall_t = -100000;
  int s_rx, s_d0, s_d1, s_w, s_p, s_done;

  always #5 clk = ~clk;

  wigend_out #(.NBITS(26), .PULSE_CYC(PA), .PERIOD_CYC(PERA), .GAP_CYC(GA)) dut_a (
    .wil_clk(clk), .rst(rst), .data(data_a), .start(start_a),
    .wigend(wig_a), .busy(busy_a), .done(done_a)
  );

  wigend_out #(.NBITS(26), .PULSE_CYC(PB), .PERIOD_CYC(PERB), .GAP_CYC(GB)) dut_b (
    .wil_clk(clk), .rst(rst), .data(data_b), .start(start_b),
    .wigend(wig_b), .busy(busy_b), .done(done_b)
  );

  always @(posedge clk) tcyc <= tcyc + 1;

  // Receiver model: decodes falling edges, checks pulse width and pulse spacing.
  always @(negedge clk) begin
    prev_a <= wig_a;
    if (wig_a == 2'b00 || wig_b == 2'b00) both_low <= both_low + 1;
    if (done_a) done_cnt <= done_cnt + 1;
    if ((prev_a & ~wig_a) != 2'b00) begin
      rx_word <= {rx_word[24:0], prev_a[1] & ~wig_a[1]};
      rx_cnt  <= rx_cnt + 1;
      if (prev_a[1] & ~wig_a[1]) d1_cnt <= d1_cnt + 1;
      else                       d0_cnt <= d0_cnt + 1;
      fall_t <= tcyc;
      if ((tcyc - fall_t) < 2 * PERA && (tcyc - fall_t) != PERA) period_err <= period_err + 1;
    end
    if ((~prev_a & wig_a) != 2'b00 && (tcyc - fall_t) != PA) width_err <= width_err + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    s_rx = rx_cnt; s_d0 = d0_cnt; s_d1 = d1_cnt;
    s_w = width_err; s_p = period_err; s_done = done_cnt;
  endtask

  task automatic send_a(input logic [25:0] w);
    data_a  = w;
    start_a = 1'b1;
    t_start = tcyc + 1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input string tag);
    int n = 0;
    while (!done_a && n < FRAME_A + 50) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, " latency"}, 32'(tcyc - t_start), 32'(FRAME_A));
    check_eq({tag, " busy@done"}, 32'(busy_a), 32'd0);
  endtask

  task automatic wait_rx(input string tag, input int nb);
    int k = 0;
    while ((rx_cnt - s_rx) < nb && k < FRAME_A) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, " bits seen"}, 32'(rx_cnt - s_rx), 32'(nb));
  endtask

  task automatic wait_cyc(input int t);
    while (tcyc < t) @(negedge clk);
  endtask

  task automatic frame_chk(input string tag, input logic [25:0] w);
    check_eq({tag, " word"}, 32'(rx_word), 32'(w));
    check_eq({tag, " pulses"}, 32'(rx_cnt - s_rx), 32'd26);
    check_eq({tag, " d1 pulses"}, 32'(d1_cnt - s_d1), 32'($countones(w)));
    check_eq({tag, " d0 pulses"}, 32'(d0_cnt - s_d0), 32'(26 - $countones(w)));
    check_eq({tag, " width errs"}, 32'(width_err - s_w), 32'd0);
    check_eq({tag, " period errs"}, 32'(period_err - s_p), 32'd0);
  endtask

  initial begin
    logic [3:0]  e;
    logic [25:0] w5;
    repeat (3) @(negedge clk);
    check_eq("rst wigend", 32'(wig_a), 32'h3);
    check_eq("rst busy", 32'(busy_a), 32'd0);
    check_eq("rst done", 32'(done_a), 32'd0);
    check_eq("rst wigend b", 32'(wig_b), 32'h3);
    rst = 1'b1;
    @(negedge clk);

    // alternating pattern, first bit is a '1' on D1
    snap();
    send_a(26'h2AAAAAA);
    check_eq("t1 busy", 32'(busy_a), 32'd1);
    check_eq("t1 first line", 32'(wig_a), 32'h1);
    wait_done_a("t1");
    frame_chk("t1", 26'h2AAAAAA);
    check_eq("t1 d1 hand", 32'(d1_cnt - s_d1), 32'd13);
    @(negedge clk);
    check_eq("t1 done drop", 32'(done_a), 32'd0);

    snap();
    send_a(26'h3FFFFFF);
    wait_done_a("t2");
    frame_chk("t2", 26'h3FFFFFF);
    check_eq("t2 d0 idle", 32'(d0_cnt - s_d0), 32'd0);
    @(negedge clk);

    snap();
    send_a(26'h0000000);
    check_eq("t3 first line", 32'(wig_a), 32'h2);
    wait_done_a("t3");
    frame_chk("t3", 26'h0000000);
    @(negedge clk);

    // starts while busy, in GAP and on the done edge are all ignored
    snap();
    send_a(26'h1234567);
    wait_rx("t4", 10);
    data_a  = 26'h3FFFFFF;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check_eq("t4 busy mid", 32'(busy_a), 32'd1);
    wait_cyc(t_start + 26 * PERA + 5);
    data_a  = 26'h0000000;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check_eq("t4 busy gap", 32'(busy_a), 32'd1);
    wait_cyc(t_start + FRAME_A - 1);
    start_a = 1'b1;
    @(negedge clk);
    check_eq("t4 done", 32'(done_a), 32'd1);
    check_eq("t4 done-edge start", 32'(busy_a), 32'd0);
    frame_chk("t4", 26'h1234567);
    snap();
    data_a  = 26'h0C0FFEE;
    t_start = tcyc + 1;
    @(negedge clk);
    start_a = 1'b0;
    check_eq("t4 restart busy", 32'(busy_a), 32'd1);
    wait_done_a("t4b");
    frame_chk("t4b", 26'h0C0FFEE);
    @(negedge clk);

    // reset mid-pulse of bit 13
    w5 = 26'h155AAAA;
    snap();
    send_a(w5);
    wait_rx("t5", 14);
    repeat (3) @(negedge clk);
    check_eq("t5 busy pre", 32'(busy_a), 32'd1);
    check_eq("t5 line pre", 32'(wig_a), 32'(w5[12] ? 2'b01 : 2'b10));
    rst = 1'b0;
    #1;
    check_eq("t5 rst wigend", 32'(wig_a), 32'h3);
    check_eq("t5 rst busy", 32'(busy_a), 32'd0);
    check_eq("t5 rst done", 32'(done_a), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    snap();
    repeat (FRAME_A + 100) @(negedge clk);
    check_eq("t5 no done", 32'(done_cnt - s_done), 32'd0);
    check_eq("t5 no pulses", 32'(rx_cnt - s_rx), 32'd0);
    check_eq("t5 idle busy", 32'(busy_a), 32'd0);
    snap();
    send_a(26'h0ABCDEF);
    wait_done_a("t5b");
    frame_chk("t5b", 26'h0ABCDEF);
    @(negedge clk);

    // tiny timing: every cycle of the 137-cycle frame against the formula
    data_b   = 26'h2F0C3A5;
    start_b  = 1'b1;
    tb_start = tcyc + 1;
    @(negedge clk);
    start_b = 1'b0;
    for (int j = 0; j <= 138; j++) begin
      if (j < 26 * PERB) begin
        if ((j % PERB) < PB) e = {(data_b[25 - j / PERB] ? 2'b01 : 2'b10), 2'b10};
        else                 e = 4'b1110;
      end else if (j < 26 * PERB + GB) begin
        e = 4'b1110;
      end else if (j == 26 * PERB + GB) begin
        e = 4'b1101;
      end else begin
        e = 4'b1100;
      end
      check_eq($sformatf("t6 cyc%0d", tcyc - tb_start), 32'({wig_b, busy_b, done_b}), 32'(e));
      @(negedge clk);
    end

    check_eq("never both low", 32'(both_low), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
